// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared opcodes, funct3 codes, FSM state and ALU op encodings
//               for the multi-cycle RV32I-subset core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        TRAP  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

endpackage

`default_nettype wire

// File: rtl/rv_regfile.sv
// ============================================================================
// Module      : rv_regfile
// Description : Architectural register file, two async reads, one sync write,
//               x0 hardwired to zero, synchronous clear on rst.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      i_raddr1,
    output logic [XLEN-1:0] o_rdata1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata2,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata
);

    localparam int c_AW = $clog2(NREGS);

    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0) && (int'(i_waddr) < NREGS)) begin
            r_regs[i_waddr[c_AW-1:0]] <= i_wdata;
        end
    end

    // Out-of-range indices read as zero; the core traps on them anyway
    assign o_rdata1 = ((i_raddr1 == 5'd0) || (int'(i_raddr1) >= NREGS)) ? '0
                    : r_regs[i_raddr1[c_AW-1:0]];
    assign o_rdata2 = ((i_raddr2 == 5'd0) || (int'(i_raddr2) >= NREGS)) ? '0
                    : r_regs[i_raddr2[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/rv_multicycle_core.sv
// ============================================================================
// Module      : rv_multicycle_core
// Description : Multi-cycle RV32I-subset core (FETCH/WAIT/EXEC/WB, sticky TRAP).
//               Define RV_CORE_CTRL_EN to enable JAL and conditional branches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_multicycle_core
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_LIMIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] result,
    output logic            retire,
    output logic            trap
);

    localparam int              c_SHW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, r_alu, r_next_pc, r_result;
    logic [4:0]      r_rd;
    logic            r_wen;

    logic [6:0]      w_opcode, w_funct7;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm_i, w_imm_u;
    logic [XLEN-1:0] w_op_a, w_op_b, w_alu, w_seq_pc, w_next_pc;
    logic [c_SHW-1:0] w_shamt;
    alu_op_t         w_alu_op;
    logic            w_wen, w_illegal, w_use_rd, w_use_rs1, w_use_rs2;
    logic            w_shift_ok, w_misalign, w_rf_we;
`ifdef RV_CORE_CTRL_EN
    logic            w_jump, w_branch, w_br_cond, w_taken;
    logic [XLEN-1:0] w_imm_b, w_imm_j, w_target;
`endif

    // The ROM word is valid throughout EXEC and is decoded directly there
    assign w_opcode = imem_rdata[6:0];
    assign w_rd     = imem_rdata[11:7];
    assign w_funct3 = imem_rdata[14:12];
    assign w_rs1    = imem_rdata[19:15];
    assign w_rs2    = imem_rdata[24:20];
    assign w_funct7 = imem_rdata[31:25];
    assign w_imm_i  = XLEN'($signed(imem_rdata[31:20]));
    assign w_imm_u  = XLEN'($signed({imem_rdata[31:12], 12'b0}));
    assign w_shift_ok = ~imem_rdata[31] && (imem_rdata[29:c_SHW+20] == '0);

    rv_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (w_rs1),
        .o_rdata1 (w_rs1_data),
        .i_raddr2 (w_rs2),
        .o_rdata2 (w_rs2_data),
        .i_we     (w_rf_we),
        .i_waddr  (r_rd),
        .i_wdata  (r_alu)
    );

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_op_a    = w_rs1_data;
        w_op_b    = w_imm_i;
        w_wen     = 1'b0;
        w_illegal = 1'b0;
        w_use_rd  = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
`ifdef RV_CORE_CTRL_EN
        w_jump    = 1'b0;
        w_branch  = 1'b0;
`endif
        case (w_opcode)
            OP_IMM: begin
                {w_use_rd, w_use_rs1, w_wen} = 3'b111;
                case (w_funct3)
                    F3_ADD:  w_alu_op = ALU_ADD;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_OR:   w_alu_op = ALU_OR;
                    F3_AND:  w_alu_op = ALU_AND;
                    F3_SLL: begin
                        w_alu_op  = ALU_SLL;
                        w_illegal = imem_rdata[30] || !w_shift_ok;
                    end
                    default: begin
                        w_alu_op  = imem_rdata[30] ? ALU_SRA : ALU_SRL;
                        w_illegal = !w_shift_ok;
                    end
                endcase
            end
            OP: begin
                {w_use_rd, w_use_rs1, w_use_rs2, w_wen} = 4'b1111;
                w_op_b    = w_rs2_data;
                w_illegal = !((w_funct7 == 7'h00) ||
                              ((w_funct7 == 7'h20) &&
                               ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR))));
                case (w_funct3)
                    F3_ADD:  w_alu_op = imem_rdata[30] ? ALU_SUB : ALU_ADD;
                    F3_SLL:  w_alu_op = ALU_SLL;
                    F3_SLT:  w_alu_op = ALU_SLT;
                    F3_SLTU: w_alu_op = ALU_SLTU;
                    F3_XOR:  w_alu_op = ALU_XOR;
                    F3_SR:   w_alu_op = imem_rdata[30] ? ALU_SRA : ALU_SRL;
                    F3_OR:   w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_AND;
                endcase
            end
            LUI: begin
                {w_use_rd, w_wen} = 2'b11;
                w_alu_op = ALU_PASSB;
                w_op_b   = w_imm_u;
            end
            AUIPC: begin
                {w_use_rd, w_wen} = 2'b11;
                w_op_a = r_pc;
                w_op_b = w_imm_u;
            end
`ifdef RV_CORE_CTRL_EN
            JAL: begin
                {w_use_rd, w_wen, w_jump} = 3'b111;
                w_op_a = r_pc;
                w_op_b = c_FOUR;
            end
            BRANCH: begin
                {w_use_rs1, w_use_rs2, w_branch} = 3'b111;
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
`endif
            default: w_illegal = 1'b1;
        endcase
        if ((w_use_rd  && (int'(w_rd)  >= NREGS)) ||
            (w_use_rs1 && (int'(w_rs1) >= NREGS)) ||
            (w_use_rs2 && (int'(w_rs2) >= NREGS))) begin
            w_illegal = 1'b1;
        end
    end

    assign w_shamt = w_op_b[c_SHW-1:0];

    always_comb begin
        case (w_alu_op)
            ALU_ADD:   w_alu = w_op_a + w_op_b;
            ALU_SUB:   w_alu = w_op_a - w_op_b;
            ALU_SLL:   w_alu = w_op_a << w_shamt;
            ALU_SLT:   w_alu = XLEN'($signed(w_op_a) < $signed(w_op_b));
            ALU_SLTU:  w_alu = XLEN'(w_op_a < w_op_b);
            ALU_XOR:   w_alu = w_op_a ^ w_op_b;
            ALU_SRL:   w_alu = w_op_a >> w_shamt;
            ALU_SRA:   w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_OR:    w_alu = w_op_a | w_op_b;
            ALU_AND:   w_alu = w_op_a & w_op_b;
            ALU_PASSB: w_alu = w_op_b;
            default:   w_alu = w_op_a + w_op_b;
        endcase
    end

    // Wrap only ever redirects sequential flow, never a taken target
    always_comb begin
        if ((PC_LIMIT != '0) && (r_pc >= PC_LIMIT)) begin
            w_seq_pc = RESET_PC;
        end else begin
            w_seq_pc = r_pc + c_FOUR;
        end
    end

`ifdef RV_CORE_CTRL_EN
    assign w_imm_b = XLEN'($signed({imem_rdata[31], imem_rdata[7], imem_rdata[30:25],
                                    imem_rdata[11:8], 1'b0}));
    assign w_imm_j = XLEN'($signed({imem_rdata[31], imem_rdata[19:12], imem_rdata[20],
                                    imem_rdata[30:21], 1'b0}));

    always_comb begin
        case (w_funct3)
            F3_BEQ:  w_br_cond = (w_rs1_data == w_rs2_data);
            F3_BNE:  w_br_cond = (w_rs1_data != w_rs2_data);
            F3_BLT:  w_br_cond = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            F3_BGE:  w_br_cond = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            F3_BLTU: w_br_cond = (w_rs1_data <  w_rs2_data);
            F3_BGEU: w_br_cond = (w_rs1_data >= w_rs2_data);
            default: w_br_cond = 1'b0;
        endcase
    end

    assign w_taken    = w_jump || (w_branch && w_br_cond);
    assign w_target   = r_pc + (w_jump ? w_imm_j : w_imm_b);
    assign w_next_pc  = w_taken ? w_target : w_seq_pc;
    assign w_misalign = w_taken && (w_target[1:0] != 2'b00);
`else
    assign w_next_pc  = w_seq_pc;
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        case (r_state)
            FETCH:   w_state_nxt = WAIT;
            WAIT:    w_state_nxt = EXEC;
            EXEC:    w_state_nxt = (w_illegal || w_misalign) ? TRAP : WB;
            WB:      w_state_nxt = FETCH;
            TRAP:    w_state_nxt = TRAP;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_comb begin
        retire  = (r_state == WB);
        trap    = (r_state == TRAP);
        w_rf_we = (r_state == WB) && r_wen;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_alu     <= '0;
            r_next_pc <= RESET_PC;
            r_result  <= '0;
            r_rd      <= '0;
            r_wen     <= 1'b0;
        end else begin
            if (r_state == EXEC) begin
                r_alu     <= w_alu;
                r_next_pc <= w_next_pc;
                r_rd      <= w_rd;
                r_wen     <= w_wen && (w_rd != 5'd0);
            end
            if (r_state == WB) begin
                r_pc <= r_next_pc;
                if (r_wen) begin
                    r_result <= r_alu;
                end
            end
        end
    end

    assign imem_addr = r_pc;
    assign result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_rv_multicycle_core.sv
// ============================================================================
// Module      : tb_rv_multicycle_core
// Description : Directed self-checking bench for rv_multicycle_core (default,
//               PC_LIMIT=20 and NREGS=16 instances); RV_CORE_CTRL_EN aware.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_multicycle_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sel   = 0;

    logic        rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [31:0] addr0, addr1, addr2, rd0, rd1, rd2, res0, res1, res2;
    logic        ret0, ret1, ret2, trp0, trp1, trp2;
    logic [31:0] rom0 [64];
    logic [31:0] rom1 [64];
    logic [31:0] rom2 [64];

    rv_multicycle_core u_dut (
        .clk(clk), .rst(rst0), .imem_addr(addr0), .imem_rdata(rd0),
        .result(res0), .retire(ret0), .trap(trp0));

    rv_multicycle_core #(.PC_LIMIT(32'd20)) u_lim (
        .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_rdata(rd1),
        .result(res1), .retire(ret1), .trap(trp1));

    rv_multicycle_core #(.NREGS(16)) u_r16 (
        .clk(clk), .rst(rst2), .imem_addr(addr2), .imem_rdata(rd2),
        .result(res2), .retire(ret2), .trap(trp2));

    always @(posedge clk) begin
        rd0 <= rom0[addr0[7:2]];
        rd1 <= rom1[addr1[7:2]];
        rd2 <= rom2[addr2[7:2]];
    end

    logic [31:0] m_addr, m_res;
    logic        m_ret, m_trap;
    always_comb begin
        case (sel)
            0:       begin m_addr = addr0; m_res = res0; m_ret = ret0; m_trap = trp0; end
            1:       begin m_addr = addr1; m_res = res1; m_ret = ret1; m_trap = trp1; end
            default: begin m_addr = addr2; m_res = res2; m_ret = ret2; m_trap = trp2; end
        endcase
    end

    function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rd);
        logic [31:0] t, a, b, c;
        t = imm; a = rs1; b = f3; c = rd;
        return {t[11:0], a[4:0], b[2:0], c[4:0], 7'b0010011};
    endfunction

    function automatic logic [31:0] er(input int f7, input int rs2, input int rs1, input int f3,
                                       input int rd);
        logic [31:0] s, t, a, b, c;
        s = f7; t = rs2; a = rs1; b = f3; c = rd;
        return {s[6:0], t[4:0], a[4:0], b[2:0], c[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] eu(input int imm, input int rd, input logic [6:0] op);
        logic [31:0] t, c;
        t = imm; c = rd;
        return {t[19:0], c[4:0], op};
    endfunction

    function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] t, s, a, b;
        t = imm; s = rs2; a = rs1; b = f3;
        return {t[12], t[10:5], s[4:0], a[4:0], b[2:0], t[4:1], t[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] ej(input int imm, input int rd);
        logic [31:0] t, c;
        t = imm; c = rd;
        return {t[20], t[10:1], t[11], t[19:12], c[4:0], 7'b1101111};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full instruction from FETCH: retire only in WB, then result and next pc
    task automatic exec(input string tag, input logic [31:0] er_v, input logic [31:0] ep);
        step(); step();
        chk({tag, "_ret_early"}, {31'b0, m_ret}, 32'd0);
        step();
        chk({tag, "_ret_wb"}, {31'b0, m_ret}, 32'd1);
        chk({tag, "_trap"}, {31'b0, m_trap}, 32'd0);
        step();
        chk({tag, "_ret_after"}, {31'b0, m_ret}, 32'd0);
        chk({tag, "_result"}, m_res, er_v);
        chk({tag, "_pc"}, m_addr, ep);
    endtask

    task automatic trap_exec(input string tag, input logic [31:0] ep);
        step(); step(); step();
        chk({tag, "_trap"}, {31'b0, m_trap}, 32'd1);
        chk({tag, "_ret"}, {31'b0, m_ret}, 32'd0);
        step(); step();
        chk({tag, "_sticky"}, {31'b0, m_trap}, 32'd1);
        chk({tag, "_pc_frozen"}, m_addr, ep);
        chk({tag, "_ret_late"}, {31'b0, m_ret}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom0[i] = 32'h0000007F;
            rom1[i] = 32'h0000007F;
            rom2[i] = 32'h0000007F;
        end
        rom0[0]  = ei(5, 0, 0, 1);
        rom0[1]  = ei(-7, 1, 0, 2);
        rom0[2]  = eu(1, 7, 7'b0010111);
        rom0[3]  = eu(32'h12345, 6, 7'b0110111);
        rom0[4]  = ei(9, 0, 0, 0);
        rom0[5]  = eu(32'h80000, 1, 7'b0110111);
        rom0[6]  = ei(32'h404, 1, 5, 3);
        rom0[7]  = ei(4, 1, 5, 4);
        rom0[8]  = er(0, 1, 0, 3, 5);
        rom0[9]  = er(32'h20, 1, 2, 0, 8);
        rom0[10] = er(0, 0, 1, 2, 9);
        rom0[11] = ei(-1, 5, 4, 10);
        rom0[12] = ei(31, 5, 1, 13);
        rom0[13] = ei(32'hF0, 2, 7, 14);
        rom0[14] = er(0, 7, 6, 6, 15);
`ifdef RV_CORE_CTRL_EN
        rom0[15] = ei(3, 0, 0, 1);
        rom0[16] = ei(0, 0, 0, 2);
        rom0[17] = ei(-1, 1, 0, 1);
        rom0[18] = ei(1, 11, 0, 11);
        rom0[19] = eb(-8, 2, 1, 1);
        rom0[20] = ej(12, 1);
        rom0[23] = ei(0, 11, 0, 12);
        rom0[24] = eb(2, 0, 0, 0);
`else
        rom0[15] = ej(12, 1);
`endif

        sel = 0;
        step(); step();
        chk("rst_pc", m_addr, 32'd0);
        chk("rst_result", m_res, 32'd0);
        chk("rst_retire", {31'b0, m_ret}, 32'd0);
        chk("rst_trap", {31'b0, m_trap}, 32'd0);
        rst0 = 1'b0;

        exec("addi5",   32'd5,          32'h04);
        exec("addi_m7", 32'hFFFFFFFE,   32'h08);
        exec("auipc",   32'h00001008,   32'h0C);
        exec("lui",     32'h12345000,   32'h10);
        exec("addi_x0", 32'h12345000,   32'h14);
        exec("lui_msb", 32'h80000000,   32'h18);
        exec("srai",    32'hF8000000,   32'h1C);
        exec("srli",    32'h08000000,   32'h20);
        exec("sltu",    32'd1,          32'h24);
        exec("sub",     32'h7FFFFFFE,   32'h28);
        exec("slt",     32'd1,          32'h2C);
        exec("xori",    32'hFFFFFFFE,   32'h30);
        exec("slli",    32'h80000000,   32'h34);
        exec("andi",    32'h000000F0,   32'h38);
        exec("or",      32'h12345008,   32'h3C);
`ifdef RV_CORE_CTRL_EN
        exec("li3", 32'd3, 32'h40);
        exec("li0", 32'd0, 32'h44);
        for (int k = 0; k < 3; k++) begin
            exec("dec", 32'(2 - k), 32'h48);
            exec("cnt", 32'(k + 1), 32'h4C);
            exec("bne", 32'(k + 1), (k < 2) ? 32'h44 : 32'h50);
        end
        exec("jal", 32'h54, 32'h5C);
        exec("mv",  32'd3,  32'h60);
        trap_exec("misalign", 32'h60);
`else
        trap_exec("jal_off", 32'h3C);
`endif

        sel = 1;
        for (int i = 0; i < 6; i++) rom1[i] = 32'h00000013;
        rst1 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exec("wrap_nop", 32'd0, (k < 5) ? 32'((k + 1) * 4) : 32'd0);
        end
        rom1[0] = 32'h0000007F;
        trap_exec("bad_op", 32'd0);
        rst1 = 1'b1;
        step();
        chk("trap_rst_trap", {31'b0, m_trap}, 32'd0);
        chk("trap_rst_pc", m_addr, 32'd0);

        sel = 2;
        rom2[0] = ei(5, 0, 0, 1);
        rst2 = 1'b0;
        step(); step(); step();
        chk("abort_in_wb", {31'b0, m_ret}, 32'd1);
        rst2 = 1'b1;
        step();
        chk("abort_result", m_res, 32'd0);
        chk("abort_pc", m_addr, 32'd0);
        chk("abort_ret", {31'b0, m_ret}, 32'd0);
        rom2[0] = ei(1, 1, 0, 3);
        rom2[1] = er(0, 2, 1, 0, 17);
        rst2 = 1'b0;
        exec("x1_kept", 32'd1, 32'h04);
        trap_exec("nregs", 32'h04);
        chk("nregs_result", m_res, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
